// File: rtl/perop_cmd_arbiter.sv
// Command-path arbiter: fixed-priority periodic-ops requester 0, round-robin hosts,
// registered output slot and in-order tag FIFO routing PHY read bursts back to requesters.
module perop_cmd_arbiter #(
  parameter int                NREQ      = 3,
  parameter int                CMD_SZ    = 8,
  parameter int                ADDR_W    = 60,
  parameter logic [CMD_SZ-1:0] RD_MASK   = 8'h03,
  parameter int                TAG_DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*CMD_SZ-1:0]   req_cmd,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [NREQ-1:0]          req_ack,
  output logic                     out_valid,
  output logic [CMD_SZ-1:0]        out_cmd,
  output logic [ADDR_W-1:0]        out_addr,
  input  logic                     out_ready,
  input  logic [511:0]             phy_rddata,
  input  logic                     phy_rdvalid,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [511:0]             rsp_data,
  output logic                     tags_full,
  output logic                     err_orphan
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int PW = $clog2(TAG_DEPTH);
  localparam int CW = PW + 1;

  logic                 out_valid_q;
  logic [CMD_SZ-1:0]    out_cmd_q;
  logic [ADDR_W-1:0]    out_addr_q;
  logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 full_q;
  logic [NREQ-1:0]      rsp_valid_q;
  logic [511:0]         rsp_data_q;
  logic                 err_orphan_q;
  logic [IW-1:0]        tag_mem [TAG_DEPTH];

  logic [NREQ-1:0]      elig;
  logic                 slot_free;
  logic                 found;
  logic [IW-1:0]        gnt_idx;
  logic [IW-1:0]        rr_sel;
  int                   rr_idx;
  logic [CMD_SZ-1:0]    sel_cmd;
  logic [ADDR_W-1:0]    sel_addr;
  logic                 push, pop;

  // Reads need a free tag; full is the registered flag, so a same-cycle pop never frees room.
  always_comb begin
    elig      = '0;
    slot_free = !out_valid_q || out_ready;
    found     = 1'b0;
    gnt_idx   = '0;
    rr_idx    = 0;
    rr_sel    = '0;
    for (int i = 0; i < NREQ; i++) begin
      elig[i] = req_valid[i] &&
                (!(|(req_cmd[i*CMD_SZ +: CMD_SZ] & RD_MASK)) || !full_q);
    end
    if (!rst && slot_free) begin
      if (elig[0]) begin
        found   = 1'b1;
        gnt_idx = '0;
      end else begin
        for (int k = 0; k < NREQ - 1; k++) begin
          rr_idx = ((int'(rr_ptr_q) - 1 + k) % (NREQ - 1)) + 1;
          rr_sel = IW'(rr_idx);
          if (!found && elig[rr_sel]) begin
            found   = 1'b1;
            gnt_idx = rr_sel;
          end
        end
      end
    end
  end

  always_comb begin
    sel_cmd  = req_cmd[int'(gnt_idx)*CMD_SZ +: CMD_SZ];
    sel_addr = req_addr[int'(gnt_idx)*ADDR_W +: ADDR_W];
    req_ack  = found ? (NREQ'(1) << gnt_idx) : '0;
    push     = found && (|(sel_cmd & RD_MASK));
    pop      = phy_rdvalid && (count_q != '0);
    count_d  = count_q + CW'(push) - CW'(pop);
    rr_ptr_d = rr_ptr_q;
    if (found && gnt_idx != '0) begin
      rr_ptr_d = (gnt_idx == IW'(NREQ - 1)) ? IW'(1) : gnt_idx + IW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_cmd_q    <= '0;
      out_addr_q   <= '0;
      rr_ptr_q     <= IW'(1);
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      full_q       <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_data_q   <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (found) begin
        out_valid_q <= 1'b1;
        out_cmd_q   <= sel_cmd;
        out_addr_q  <= sel_addr;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end
      rr_ptr_q <= rr_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CW'(TAG_DEPTH));
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop) begin
        rd_ptr_q    <= rd_ptr_q + PW'(1);
        rsp_valid_q <= NREQ'(1) << tag_mem[rd_ptr_q];
        rsp_data_q  <= phy_rddata;
      end else begin
        rsp_valid_q <= '0;
      end
      // Empty FIFO means no owner, even if a read is being pushed this same cycle.
      if (phy_rdvalid && count_q == '0) err_orphan_q <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr_q] <= gnt_idx;
  end

  assign out_valid  = out_valid_q;
  assign out_cmd    = out_cmd_q;
  assign out_addr   = out_addr_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_data   = rsp_data_q;
  assign tags_full  = full_q;
  assign err_orphan = err_orphan_q;

endmodule

// File: tb/tb_perop_cmd_arbiter.sv
// Bench for perop_cmd_arbiter: directed scenarios plus random traffic against a
// queue-based reference model of the grant, slot and tag-return rules.
module tb_perop_cmd_arbiter;
  localparam int NREQ = 3, CMD_SZ = 8, ADDR_W = 60, TAG_DEPTH = 8;
  localparam logic [7:0] RD_MASK = 8'h03;

  logic                   clk = 1'b0;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ*CMD_SZ-1:0] req_cmd;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ-1:0]        req_ack;
  logic                   out_valid;
  logic [CMD_SZ-1:0]      out_cmd;
  logic [ADDR_W-1:0]      out_addr;
  logic                   out_ready;
  logic [511:0]           phy_rddata;
  logic                   phy_rdvalid;
  logic [NREQ-1:0]        rsp_valid;
  logic [511:0]           rsp_data;
  logic                   tags_full;
  logic                   err_orphan;

  int errors = 0;
  int checks = 0;

  perop_cmd_arbiter #(.NREQ(NREQ), .CMD_SZ(CMD_SZ), .ADDR_W(ADDR_W),
                      .RD_MASK(RD_MASK), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_cmd(req_cmd),
    .req_addr(req_addr), .req_ack(req_ack), .out_valid(out_valid),
    .out_cmd(out_cmd), .out_addr(out_addr), .out_ready(out_ready),
    .phy_rddata(phy_rddata), .phy_rdvalid(phy_rdvalid), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .tags_full(tags_full), .err_orphan(err_orphan)
  );

  always #5 clk = ~clk;

  // Reference model state
  int                q[$];
  bit                m_valid;
  logic [7:0]        m_cmd;
  logic [59:0]       m_addr;
  int                m_ptr;
  bit                m_full;
  bit                m_orphan;
  logic [NREQ-1:0]   m_rsp_valid;
  logic [511:0]      m_rsp_data;
  int                exp_gnt;
  logic [NREQ-1:0]   exp_ack;

  function automatic bit is_rd(input logic [7:0] c);
    return (c & RD_MASK) != 8'h00;
  endfunction

  function automatic bit eligible(input int i);
    logic [7:0] c;
    c = req_cmd[i*CMD_SZ +: CMD_SZ];
    return req_valid[i] && (!is_rd(c) || !m_full);
  endfunction

  function automatic logic [59:0] rnd_addr();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[59:0];
  endfunction

  function automatic logic [511:0] rnd_data();
    logic [511:0] r;
    for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic set_req(input int i, input logic [7:0] c, input logic [59:0] a);
    req_cmd[i*CMD_SZ +: CMD_SZ] = c;
    req_addr[i*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic model_pre();
    int j;
    exp_gnt = -1;
    if (!rst && (!m_valid || out_ready)) begin
      if (eligible(0)) exp_gnt = 0;
      else begin
        j = m_ptr;
        for (int k = 0; k < NREQ - 1; k++) begin
          if (exp_gnt < 0 && eligible(j)) exp_gnt = j;
          j = (j == NREQ - 1) ? 1 : j + 1;
        end
      end
    end
    exp_ack = (exp_gnt >= 0) ? (NREQ'(1) << exp_gnt) : '0;
  endtask

  task automatic model_post();
    logic [7:0] c;
    if (rst) begin
      q.delete();
      m_valid = 0; m_cmd = '0; m_addr = '0; m_ptr = 1; m_full = 0;
      m_orphan = 0; m_rsp_valid = '0; m_rsp_data = '0;
      return;
    end
    // Return path looks at the queue as it stood before this cycle's push.
    if (phy_rdvalid) begin
      if (q.size() > 0) begin
        m_rsp_valid = NREQ'(1) << q.pop_front();
        m_rsp_data  = phy_rddata;
      end else begin
        m_orphan    = 1;
        m_rsp_valid = '0;
      end
    end else begin
      m_rsp_valid = '0;
    end
    if (exp_gnt >= 0) begin
      c = req_cmd[exp_gnt*CMD_SZ +: CMD_SZ];
      if (is_rd(c)) q.push_back(exp_gnt);
      m_valid = 1;
      m_cmd   = c;
      m_addr  = req_addr[exp_gnt*ADDR_W +: ADDR_W];
      if (exp_gnt > 0) m_ptr = (exp_gnt == NREQ - 1) ? 1 : exp_gnt + 1;
    end else if (out_ready) begin
      m_valid = 0;
    end
    m_full = (q.size() == TAG_DEPTH);
  endtask

  task automatic settle();
    #1;
    model_pre();
  endtask

  task automatic advance();
    model_post();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1; req_valid = '0; phy_rdvalid = 0; out_ready = 0;
    settle();
    advance();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 1; req_valid = 3'b111; out_ready = 1; phy_rdvalid = 1;
    phy_rddata = rnd_data();
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h04, rnd_addr());
    settle();
    checks++;
    if (req_ack !== 3'b000) begin
      errors++; $display("FAIL reset_ack: got %b expected 000", req_ack);
    end
    advance();
    checks++;
    if ({out_valid, rsp_valid, err_orphan, tags_full} !== 6'b0) begin
      errors++;
      $display("FAIL reset_flags: got v=%b rsp=%b orph=%b full=%b expected all 0",
               out_valid, rsp_valid, err_orphan, tags_full);
    end
    checks++;
    if (out_cmd !== 8'h00 || out_addr !== 60'h0 || rsp_data !== 512'h0) begin
      errors++; $display("FAIL reset_data: got cmd=%h addr=%h expected 0", out_cmd, out_addr);
    end
    rst = 0; req_valid = '0; phy_rdvalid = 0;
  endtask

  task automatic test_single_read();
    logic [59:0]  a;
    logic [511:0] d;
    apply_reset();
    a = rnd_addr();
    set_req(1, 8'h01, a); req_valid = 3'b010; out_ready = 1;
    settle();
    checks++;
    if (req_ack !== 3'b010) begin
      errors++; $display("FAIL single_ack: got %b expected 010", req_ack);
    end
    advance();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_cmd !== 8'h01 || out_addr !== a) begin
      errors++;
      $display("FAIL single_slot: got v=%b cmd=%h addr=%h expected 1/01/%h", out_valid, out_cmd, out_addr, a);
    end
    for (int n = 0; n < 4; n++) begin settle(); advance(); end
    checks++;
    if (rsp_valid !== 3'b000 || out_valid !== 1'b0) begin
      errors++; $display("FAIL single_idle: got rsp=%b v=%b expected 000/0", rsp_valid, out_valid);
    end
    d = rnd_data(); phy_rddata = d; phy_rdvalid = 1;
    settle(); advance();
    phy_rdvalid = 0;
    checks++;
    if (rsp_valid !== 3'b010 || rsp_data !== d) begin
      errors++; $display("FAIL single_rsp: got rsp=%b data_ok=%0d expected 010/1", rsp_valid, rsp_data === d);
    end
    settle(); advance();
    checks++;
    if (rsp_valid !== 3'b000 || rsp_data !== d) begin
      errors++; $display("FAIL single_rsp_clear: got %b expected 000 with data held", rsp_valid);
    end
  endtask

  task automatic test_contention();
    logic [2:0] seq [4];
    seq = '{3'b010, 3'b100, 3'b010, 3'b100};
    apply_reset();
    out_ready = 1;
    for (int i = 0; i < NREQ; i++) set_req(i, 8'h04, rnd_addr());
    req_valid = 3'b111;
    for (int n = 0; n < 3; n++) begin
      settle();
      checks++;
      if (req_ack !== 3'b001) begin
        errors++; $display("FAIL contention_req0_%0d: got %b expected 001", n, req_ack);
      end
      advance();
      set_req(0, 8'h08, rnd_addr());
    end
    req_valid = 3'b110;
    for (int n = 0; n < 4; n++) begin
      settle();
      checks++;
      if (req_ack !== seq[n]) begin
        errors++; $display("FAIL contention_rr_%0d: got %b expected %b", n, req_ack, seq[n]);
      end
      advance();
    end
    req_valid = '0;
    settle(); advance();
  endtask

  task automatic test_backpressure();
    logic [59:0] a0, a1;
    int acks;
    apply_reset();
    a0 = rnd_addr(); a1 = rnd_addr(); acks = 0;
    set_req(1, 8'h08, a0); req_valid = 3'b010; out_ready = 0;
    settle();
    checks++;
    if (req_ack !== 3'b010) begin
      errors++; $display("FAIL bp_first_ack: got %b expected 010", req_ack);
    end
    advance();
    set_req(1, 8'h10, a1);
    for (int n = 0; n < 10; n++) begin
      settle();
      if (req_ack !== 3'b000) acks++;
      advance();
      checks++;
      if (out_valid !== 1'b1 || out_cmd !== 8'h08 || out_addr !== a0) begin
        errors++;
        $display("FAIL bp_hold_%0d: got v=%b cmd=%h addr=%h expected 1/08/%h", n, out_valid, out_cmd, out_addr, a0);
      end
    end
    checks++;
    if (acks !== 0) begin
      errors++; $display("FAIL bp_extra_acks: got %0d expected 0", acks);
    end
    out_ready = 1;
    settle();
    checks++;
    if (req_ack !== 3'b010) begin
      errors++; $display("FAIL bp_second_ack: got %b expected 010", req_ack);
    end
    advance();
    req_valid = '0;
    checks++;
    if (out_valid !== 1'b1 || out_cmd !== 8'h10 || out_addr !== a1) begin
      errors++; $display("FAIL bp_second_slot: got cmd=%h addr=%h expected 10/%h", out_cmd, out_addr, a1);
    end
    settle(); advance();
  endtask

  task automatic test_tag_full();
    apply_reset();
    out_ready = 1;
    set_req(2, 8'h02, rnd_addr()); req_valid = 3'b100;
    for (int n = 0; n < TAG_DEPTH; n++) begin
      settle();
      checks++;
      if (req_ack !== 3'b100) begin
        errors++; $display("FAIL full_fill_%0d: got %b expected 100", n, req_ack);
      end
      advance();
      set_req(2, 8'h02, rnd_addr());
    end
    checks++;
    if (tags_full !== 1'b1) begin
      errors++; $display("FAIL full_flag: got %b expected 1", tags_full);
    end
    set_req(1, 8'h04, rnd_addr()); req_valid = 3'b110;
    settle();
    checks++;
    if (req_ack !== 3'b010) begin
      errors++; $display("FAIL full_write_pass: got %b expected 010", req_ack);
    end
    advance();
    req_valid = 3'b100; phy_rdvalid = 1; phy_rddata = rnd_data();
    settle();
    checks++;
    if (req_ack !== 3'b000) begin
      errors++; $display("FAIL full_pop_same_cycle: got %b expected 000", req_ack);
    end
    advance();
    phy_rdvalid = 0;
    checks++;
    if (rsp_valid !== 3'b100 || tags_full !== 1'b0) begin
      errors++; $display("FAIL full_pop: got rsp=%b full=%b expected 100/0", rsp_valid, tags_full);
    end
    settle();
    checks++;
    if (req_ack !== 3'b100) begin
      errors++; $display("FAIL full_ninth_ack: got %b expected 100", req_ack);
    end
    advance();
    req_valid = '0;
    for (int n = 0; n < TAG_DEPTH; n++) begin
      phy_rdvalid = 1; phy_rddata = rnd_data();
      settle(); advance();
      checks++;
      if (rsp_valid !== 3'b100) begin
        errors++; $display("FAIL full_drain_%0d: got %b expected 100", n, rsp_valid);
      end
    end
    phy_rdvalid = 0;
  endtask

  task automatic test_interleaved();
    int ord [4];
    logic [511:0] d;
    ord = '{1, 2, 0, 1};
    apply_reset();
    out_ready = 1;
    for (int n = 0; n < 4; n++) begin
      set_req(ord[n], (n % 2 == 0) ? 8'h01 : 8'h02, rnd_addr());
      req_valid = NREQ'(1) << ord[n];
      settle();
      checks++;
      if (req_ack !== (NREQ'(1) << ord[n])) begin
        errors++; $display("FAIL inter_ack_%0d: got %b expected %b", n, req_ack, NREQ'(1) << ord[n]);
      end
      advance();
      req_valid = '0;
    end
    for (int n = 0; n < 4; n++) begin
      d = rnd_data(); phy_rddata = d; phy_rdvalid = 1;
      settle(); advance();
      checks++;
      if (rsp_valid !== (NREQ'(1) << ord[n]) || rsp_data !== d) begin
        errors++;
        $display("FAIL inter_rsp_%0d: got %b data_ok=%0d expected %b", n, rsp_valid, rsp_data === d, NREQ'(1) << ord[n]);
      end
    end
    phy_rdvalid = 0;
  endtask

  task automatic test_orphan();
    phy_rdvalid = 1; phy_rddata = rnd_data();
    settle(); advance();
    phy_rdvalid = 0;
    checks++;
    if (rsp_valid !== 3'b000 || err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_set: got rsp=%b err=%b expected 000/1", rsp_valid, err_orphan);
    end
    for (int n = 0; n < 3; n++) begin settle(); advance(); end
    checks++;
    if (err_orphan !== 1'b1) begin
      errors++; $display("FAIL orphan_sticky: got %b expected 1", err_orphan);
    end
    set_req(1, 8'h04, rnd_addr()); req_valid = 3'b010; out_ready = 0;
    settle(); advance();
    req_valid = '0;
    rst = 1; set_req(2, 8'h04, rnd_addr()); req_valid = 3'b100;
    settle();
    checks++;
    if (req_ack !== 3'b000) begin
      errors++; $display("FAIL orphan_rst_ack: got %b expected 000", req_ack);
    end
    advance();
    rst = 0; req_valid = '0;
    checks++;
    if (err_orphan !== 1'b0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL orphan_rst_clear: got err=%b v=%b expected 0/0", err_orphan, out_valid);
    end
  endtask

  task automatic test_random();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, (i == 0) ? 5 : 1) == 0) begin
          set_req(i, 8'(1 << $urandom_range(0, 7)), rnd_addr());
          req_valid[i] = 1'b1;
        end
      end
      out_ready   = ($urandom_range(0, 3) != 0);
      phy_rdvalid = ($urandom_range(0, (cyc < 1500) ? 7 : 2) == 0);
      phy_rddata  = rnd_data();
      rst         = ($urandom_range(0, 299) == 0);
      settle();
      checks++;
      if (req_ack !== exp_ack) begin
        errors++; $display("FAIL rand_ack@%0d: got %b expected %b", cyc, req_ack, exp_ack);
      end
      advance();
      req_valid = req_valid & ~exp_ack;
      checks++;
      if (out_valid !== m_valid || out_cmd !== m_cmd || out_addr !== m_addr) begin
        errors++;
        $display("FAIL rand_slot@%0d: got v=%b cmd=%h addr=%h expected v=%b cmd=%h addr=%h",
                 cyc, out_valid, out_cmd, out_addr, m_valid, m_cmd, m_addr);
      end
      checks++;
      if (rsp_valid !== m_rsp_valid || rsp_data !== m_rsp_data) begin
        errors++; $display("FAIL rand_rsp@%0d: got %b expected %b", cyc, rsp_valid, m_rsp_valid);
      end
      checks++;
      if (tags_full !== m_full || err_orphan !== m_orphan) begin
        errors++;
        $display("FAIL rand_flags@%0d: got full=%b orph=%b expected full=%b orph=%b",
                 cyc, tags_full, err_orphan, m_full, m_orphan);
      end
    end
    rst = 0; req_valid = '0; phy_rdvalid = 0;
  endtask

  initial begin
    rst = 1; req_valid = '0; req_cmd = '0; req_addr = '0;
    out_ready = 0; phy_rdvalid = 0; phy_rddata = '0;
    test_reset();
    test_single_read();
    test_contention();
    test_backpressure();
    test_tag_full();
    test_interleaved();
    test_orphan();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
